vga_scan_controller: RTL and testbench

Generates 640x480@60 Hz VGA scan timing and sequences the 2048 display. Drives the pixel coordinates consumed by the video generator, then registers the returned colour with matching sync and blank signals. Runs a screen-mode state machine (START/PLAY/OVER) that changes only on frame boundaries and provides a frame-rate blink flag for text. Sits between the video generator and the VGA DAC pins.

---
 rtl/vga_scan_controller.sv | 202 ++++++++++++++++++++
 tb/tb_vga_scan_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// vga_scan_controller
//
// Generates VGA raster timing (640x480@60 Hz by default) for the 2048 display.
// Also runs the START/PLAY/OVER screen-mode machine and the text blink phase.
// The scan coordinates go out combinationally to a purely combinational video
// generator. The colour it returns is registered together with the matching
// sync and blank signals, so every pin output lags x,y by exactly one clock.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   start_btn    asynchronous start button, active-high
//   game_over    game-over level, already synchronous to clk
//   r_in/g_in/b_in  colour from the video generator for the current x,y
//   x, y         current scan coordinates (blanking values are legal)
//   frame_start  high while the counters sit at (0,0)
//   screen       0=START, 1=PLAY, 2=OVER
//   blink        text blink phase
//   hsync/vsync  active-low sync, registered
//   blank_n      high in the active area, registered
//   r, g, b      registered colour, zero while blanked
module vga_scan_controller #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic [1:0] screen,
  output logic       blink,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Frame counter must hold 0..BLINK_FRAMES-1; keep at least one bit.
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StPlay  = 2'd1,
    StOver  = 2'd2
  } screen_e;

  // Scan counters
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       line_end;
  logic       frame_end;

  // Button path
  logic sync1_q, sync2_q, prev_q;
  logic start_pulse;
  logic pending_q, pending_d;

  // Screen machine and blink
  screen_e       screen_q, screen_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;

  // Output stage
  logic       active;
  logic       hs_n, vs_n;
  logic       hsync_q, vsync_q, blank_n_q;
  logic [7:0] r_q, g_q, b_q;

  // frame_end marks the edge on which the counters wrap to (0,0); every
  // frame-rate decision is taken on that edge so it holds for a whole frame.
  assign line_end  = (h_cnt_q == H_LAST);
  assign frame_end = line_end && (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = line_end ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (line_end) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_n   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
  assign vs_n   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

  assign start_pulse = sync2_q & ~prev_q;

  // A pulse landing on the boundary edge is kept for the following boundary,
  // since the machine evaluates the old pending value on that edge.
  always_comb begin
    pending_d = pending_q | start_pulse;
    if (frame_end) begin
      pending_d = start_pulse;
    end
  end

  always_comb begin
    screen_d = screen_q;
    if (frame_end) begin
      case (screen_q)
        StStart: if (pending_q) screen_d = StPlay;
        StPlay:  if (game_over) screen_d = StOver;
        StOver:  if (pending_q) screen_d = StStart;
        default: screen_d = StStart;
      endcase
    end
  end

  // A screen change restarts the blink so new text always appears lit.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_end) begin
      if (screen_d != screen_q) begin
        frame_cnt_d = '0;
        blink_d     = 1'b1;
      end else if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      pending_q   <= 1'b0;
      screen_q    <= StStart;
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      blank_n_q   <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      sync1_q     <= start_btn;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      pending_q   <= pending_d;
      screen_q    <= screen_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      hsync_q     <= hs_n;
      vsync_q     <= vs_n;
      blank_n_q   <= active;
      r_q         <= active ? r_in : 8'd0;
      g_q         <= active ? g_in : 8'd0;
      b_q         <= active ? b_in : 8'd0;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign screen      = screen_q;
  assign blink       = blink_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller using a reduced raster so that many
// frames fit in a short run: 20x12 total (10x6 active), 240 cycles per frame.
// hsync low for x in [12,14], vsync low for y in [8,9], blink half-period 3.
module tb_vga_scan_controller;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       game_over;
  logic [7:0] r_in, g_in, b_in;
  logic [9:0] x, y;
  logic       frame_start;
  logic [1:0] screen;
  logic       blink;
  logic       hsync, vsync, blank_n;
  logic [7:0] r, g, b;

  int compared   = 0;
  int mismatched = 0;

  vga_scan_controller #(
    .H_ACTIVE    (10),
    .H_FP        (2),
    .H_SYNC      (3),
    .H_BP        (5),
    .V_ACTIVE    (6),
    .V_FP        (2),
    .V_SYNC      (2),
    .V_BP        (2),
    .BLINK_FRAMES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .game_over  (game_over),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .screen     (screen),
    .blink      (blink),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank_n    (blank_n),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  // Combinational video generator
  assign r_in = x[7:0];
  assign g_in = y[7:0];
  assign b_in = 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input int tx, input int ty);
    int n = 0;
    while (!(x == 10'(tx) && y == 10'(ty)) && n < 400) begin
      tick();
      n++;
    end
    compared++;
    assert (n < 400)
    else begin
      mismatched++;
      $error("FAIL wait_xy(%0d,%0d): observed timeout at (%0d,%0d) expected arrival", tx, ty, x, y);
    end
  endtask

  task automatic next_frame();
    int n = 0;
    tick();
    while (!frame_start && n < 300) begin
      tick();
      n++;
    end
    compared++;
    assert (n < 300)
    else begin
      mismatched++;
      $error("FAIL next_frame: observed timeout expected frame_start");
    end
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    repeat (3) tick();
    start_btn = 1'b0;
  endtask

  initial begin
    int hs, vs, bl, fs;
    rst       = 1'b1;
    start_btn = 1'b0;
    game_over = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd1);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_blank_n", 32'(blank_n), 32'd0);
    check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check("rst_screen", 32'(screen), 32'd0);
    check("rst_blink", 32'(blink), 32'd1);

    rst = 1'b0;

    // Frames 0 and 1: sync/blank pulse widths per frame
    for (int f = 0; f < 2; f++) begin
      hs = 0; vs = 0; bl = 0; fs = 0;
      for (int i = 0; i < 240; i++) begin
        tick();
        if (!hsync) hs++;
        if (!vsync) vs++;
        if (blank_n) bl++;
        if (frame_start) fs++;
      end
      check($sformatf("hsync_low_f%0d", f), 32'(hs), 32'd36);
      check($sformatf("vsync_low_f%0d", f), 32'(vs), 32'd40);
      check($sformatf("blank_n_high_f%0d", f), 32'(bl), 32'd60);
      check($sformatf("frame_start_f%0d", f), 32'(fs), 32'd1);
    end
    check("f2_frame_start", 32'(frame_start), 32'd1);
    check("f2_blink", 32'(blink), 32'd1);
    check("f2_screen", 32'(screen), 32'd0);

    // Frame 2: pixel pipeline at the last active pixel and first blank pixel
    wait_xy(9, 5);
    tick();
    check("last_px_r", 32'(r), 32'h09);
    check("last_px_g", 32'(g), 32'h05);
    check("last_px_b", 32'(b), 32'hA5);
    check("last_px_blank_n", 32'(blank_n), 32'd1);
    tick();
    check("blank_px_rgb", {8'd0, r, g, b}, 32'd0);
    check("blank_px_blank_n", 32'(blank_n), 32'd0);
    tick();
    check("hsync_before", 32'(hsync), 32'd1);
    tick();
    check("hsync_first", 32'(hsync), 32'd0);

    // Blink phase through frames 3..6
    next_frame();
    check("blink_f3", 32'(blink), 32'd0);
    next_frame();
    check("blink_f4", 32'(blink), 32'd0);
    next_frame();
    check("blink_f5", 32'(blink), 32'd0);
    next_frame();
    check("blink_f6", 32'(blink), 32'd1);

    // Start pulse mid-frame waits for the boundary
    wait_xy(5, 3);
    pulse_start();
    tick();
    tick();
    check("start_hold_mid", 32'(screen), 32'd0);
    wait_xy(19, 11);
    check("start_hold_end", 32'(screen), 32'd0);
    next_frame();
    check("play_f7_screen", 32'(screen), 32'd1);
    check("play_f7_blink", 32'(blink), 32'd1);

    // Start pulse in PLAY is discarded; blink counter restarted on entry
    wait_xy(5, 3);
    pulse_start();
    next_frame();
    check("play_f8_screen", 32'(screen), 32'd1);
    check("play_f8_blink", 32'(blink), 32'd1);
    next_frame();
    check("play_f9_blink", 32'(blink), 32'd1);
    next_frame();
    check("play_f10_blink", 32'(blink), 32'd0);
    check("play_f10_screen", 32'(screen), 32'd1);

    // game_over mid-frame takes effect at the next boundary
    wait_xy(4, 3);
    game_over = 1'b1;
    tick();
    check("over_wait_mid", 32'(screen), 32'd1);
    next_frame();
    check("over_f11_screen", 32'(screen), 32'd2);
    check("over_f11_blink", 32'(blink), 32'd1);
    next_frame();
    check("over_f12_screen", 32'(screen), 32'd2);

    // OVER -> START on a fresh pulse; game_over held high is ignored
    wait_xy(5, 3);
    pulse_start();
    wait_xy(19, 11);
    check("over_hold_end", 32'(screen), 32'd2);
    next_frame();
    check("start_f13_screen", 32'(screen), 32'd0);
    check("start_f13_blink", 32'(blink), 32'd1);

    // Pulse landing on the boundary edge applies one frame later
    wait_xy(17, 11);
    pulse_start();
    check("edge_f14_frame_start", 32'(frame_start), 32'd1);
    check("edge_f14_screen", 32'(screen), 32'd0);
    game_over = 1'b0;
    next_frame();
    check("edge_f15_screen", 32'(screen), 32'd1);

    // Asynchronous reset mid-frame in PLAY
    wait_xy(6, 4);
    check("pre_rst_blank_n", 32'(blank_n), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_x", 32'(x), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_frame_start", 32'(frame_start), 32'd1);
    check("arst_sync", {30'd0, hsync, vsync}, 32'd3);
    check("arst_blank_n", 32'(blank_n), 32'd0);
    check("arst_rgb", {8'd0, r, g, b}, 32'd0);
    check("arst_screen", 32'(screen), 32'd0);
    check("arst_blink", 32'(blink), 32'd1);
    tick();
    rst = 1'b0;
    check("rel_x0", 32'(x), 32'd0);
    tick();
    check("rel_x1", 32'(x), 32'd1);
    check("rel_y", 32'(y), 32'd0);
    check("rel_screen", 32'(screen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
